pipeline_ctrl: RTL

// - Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
// - Combines ID load-use hazard, ID branch/jump redirect, multi-cycle EX mul/div occupancy and MEM data-memory wait states.
// - Drives per-stage write-enable and bubble controls.
// - Owns FSM RUN/MULDIV/MEMWAIT; replaces the ad-hoc Stall/IFWrite logic in the ID stage.

---
 rtl/pipeline_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, redirect,
// mul/div occupancy and data-memory wait states into per-stage enables and bubbles.
module pipeline_ctrl #(
    parameter int MULDIV_CYCLES = 33,
    parameter int MEM_TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       MemRead_ex,
    input  logic [4:0] rdAddr_ex,
    input  logic [4:0] rs1Addr_id,
    input  logic [4:0] rs2Addr_id,
    input  logic       Branch,
    input  logic       Jump,
    input  logic       MulDivStart_ex,
    input  logic       MemReq_mem,
    input  logic       MemReady_mem,
    output logic       PCWrite,
    output logic       IFWrite,
    output logic       IFFlush,
    output logic       IDEXWrite,
    output logic       IDBubble,
    output logic       EXMEMWrite,
    output logic       EXBubble,
    output logic       MEMWBBubble,
    output logic       Stall,
    output logic       MulDivBusy,
    output logic       MemErr
);
    localparam int MDW = $clog2(MULDIV_CYCLES + 1);

    typedef enum logic [1:0] {RUN, MULDIV, MEMWAIT} state_t;

    state_t         state_q, state_d;
    logic           ret_md_q, ret_md_d;
    logic [MDW-1:0] mdcnt_q, mdcnt_d;
    logic [7:0]     wcnt_q, wcnt_d;
    logic           mem_err_q, mem_err_d;

    logic luse, mfrz, redir, md_act;

    assign luse  = MemRead_ex && (rdAddr_ex != 5'd0) &&
                   ((rdAddr_ex == rs1Addr_id) || (rdAddr_ex == rs2Addr_id));
    assign mfrz  = MemReq_mem && !MemReady_mem;
    assign redir = Branch || Jump;
    // A mul/div frozen by memory still owns EX; the release cycle counts as progress.
    assign md_act = (state_q == MULDIV) || (state_q == MEMWAIT && ret_md_q);

    always_comb begin
        state_d   = state_q;
        ret_md_d  = ret_md_q;
        mdcnt_d   = mdcnt_q;
        wcnt_d    = wcnt_q;
        case (state_q)
            RUN: begin
                if (mfrz) begin
                    state_d  = MEMWAIT;
                    ret_md_d = 1'b0;
                    wcnt_d   = 8'd1;
                end else if (MulDivStart_ex) begin
                    state_d = MULDIV;
                    mdcnt_d = MDW'(MULDIV_CYCLES - 1);
                end
            end
            MULDIV: begin
                if (mfrz) begin
                    state_d  = MEMWAIT;
                    ret_md_d = 1'b1;
                    wcnt_d   = 8'd1;
                end else if (mdcnt_q == MDW'(1)) begin
                    state_d = RUN;
                    mdcnt_d = '0;
                end else begin
                    mdcnt_d = mdcnt_q - MDW'(1);
                end
            end
            MEMWAIT: begin
                if (MemReady_mem) begin
                    if (ret_md_q && mdcnt_q > MDW'(1)) begin
                        state_d = MULDIV;
                        mdcnt_d = mdcnt_q - MDW'(1);
                    end else begin
                        state_d = RUN;
                        mdcnt_d = '0;
                    end
                end else if (wcnt_q != 8'hFF) begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: state_d = RUN;
        endcase
        mem_err_d = mem_err_q ||
                    ((MEM_TIMEOUT != 0) && (state_d == MEMWAIT) && (wcnt_d == 8'(MEM_TIMEOUT)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            ret_md_q  <= 1'b0;
            mdcnt_q   <= '0;
            wcnt_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_md_q  <= ret_md_d;
            mdcnt_q   <= mdcnt_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Outputs stay combinational so a memory ready releases the pipe in the same cycle.
    always_comb begin
        PCWrite     = 1'b1;
        IFWrite     = 1'b1;
        IFFlush     = 1'b0;
        IDEXWrite   = 1'b1;
        IDBubble    = 1'b0;
        EXMEMWrite  = 1'b1;
        EXBubble    = 1'b0;
        MEMWBBubble = 1'b0;
        Stall       = 1'b0;
        if (mfrz) begin
            PCWrite     = 1'b0;
            IFWrite     = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMWrite  = 1'b0;
            MEMWBBubble = 1'b1;
        end else if (md_act) begin
            PCWrite   = 1'b0;
            IFWrite   = 1'b0;
            IDEXWrite = 1'b0;
            EXBubble  = 1'b1;
        end else if (luse) begin
            PCWrite  = 1'b0;
            IFWrite  = 1'b0;
            IDBubble = 1'b1;
            Stall    = 1'b1;
        end else if (redir) begin
            IFFlush = 1'b1;
        end
    end

    // The accepting start cycle counts as busy, giving MULDIV_CYCLES busy cycles in total.
    assign MulDivBusy = md_act || (state_q == RUN && MulDivStart_ex && !mfrz);
    assign MemErr     = mem_err_q;
endmodule
